// File: rtl/roi_capture_sched.sv
// Round-robin capture scheduler: grants one of two requesters a single-frame
// ROI capture and streams qualifying pixel addresses to the capture buffer.
module roi_capture_sched #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iVGA_VS,
  input  logic              iVGA_BLANK_N,
  input  logic [12:0]       x_count,
  input  logic [12:0]       y_count,
  input  logic [1:0]        req,
  input  logic [51:0]       roi0,
  input  logic [51:0]       roi1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, WAIT_SYNC, WAIT_FRAME, CAPTURE, FINISH} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              ovf_q, ovf_d;
  logic              full_q, full_d;
  logic              last_q, last_d;
  logic [51:0]       roi_q, roi_d;

  logic [12:0] rx0, ry0, rx1, ry1;
  logic        roi_bad, in_win, qual, full_now, drop, win1;

  assign rx0 = roi_q[51:39];
  assign ry0 = roi_q[38:26];
  assign rx1 = roi_q[25:13];
  assign ry1 = roi_q[12:0];

  assign roi_bad  = (rx0 > rx1) || (ry0 > ry1);
  assign in_win   = (x_count >= rx0) && (x_count <= rx1) &&
                    (y_count >= ry0) && (y_count <= ry1);
  assign qual     = (state_q == CAPTURE) && iVGA_BLANK_N && in_win;
  // The write in flight this cycle may be the last buffer slot.
  assign full_now = full_q || (wr_en_q && (wr_addr_q == ADDR_MAX));
  assign drop     = |(grant_q & ~req);
  assign win1     = last_q ? ~req[0] : req[1];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = 2'b00;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    ovf_d     = ovf_q;
    full_d    = full_q;
    last_d    = last_q;
    roi_d     = roi_q;

    if (wr_en_q) begin
      if (wr_addr_q == ADDR_MAX) full_d = 1'b1;
      else                       wr_addr_d = wr_addr_q + 1'b1;
    end

    if (qual) begin
      if (full_now) ovf_d   = 1'b1;
      else          wr_en_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = win1 ? 2'b10 : 2'b01;
          roi_d     = win1 ? roi1 : roi0;
          wr_addr_d = '0;
          ovf_d     = 1'b0;
          full_d    = 1'b0;
          state_d   = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (roi_bad)       state_d = FINISH;
        else if (!iVGA_VS) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (iVGA_VS) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!iVGA_VS || ((y_count > ry1) && !iVGA_BLANK_N)) state_d = FINISH;
      end
      FINISH: begin
        done_d  = grant_q;
        err_d   = roi_bad || ovf_q;
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Owner withdrew: silent abort, but it still counts as served.
    if ((state_q != IDLE) && drop) begin
      state_d = IDLE;
      grant_d = 2'b00;
      done_d  = 2'b00;
      err_d   = 1'b0;
      last_d  = grant_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      last_q    <= 1'b1;
      roi_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
      last_q    <= last_d;
      roi_q     <= roi_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: doc/roi_capture_sched.md
ROI_CAPTURE_SCHED -- requirements
Module: roi_capture_sched

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, giving the capture-buffer address width.
REQ-002 The block SHALL have port clk, input, 1 bit, the camera pixel clock.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port iVGA_VS, input, 1 bit, the vertical sync, low between frames.
REQ-005 The block SHALL have port iVGA_BLANK_N, input, 1 bit, high when pixel data is valid.
REQ-006 The block SHALL have ports x_count and y_count, inputs, 13 bits each, giving the current pixel position from the pixel counter.
REQ-007 The block SHALL have port req, input, 2 bits; req[i] is the capture request from requester i.
REQ-008 The block SHALL have ports roi0 and roi1, inputs, 52 bits each, packed {x0,y0,x1,y1} at 13 bits per field; these are inclusive window bounds.
REQ-009 The block SHALL have port grant, output, 2 bits, one-hot, giving the owner of the current capture.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-011 The block SHALL have ports wr_en (output, 1 bit) and wr_addr (output, ADDR_W bits), the buffer write strobe and address.
REQ-012 The block SHALL have port done, output, 2 bits, a one-cycle completion pulse per requester.
REQ-013 The block SHALL have port err, output, 1 bit, pulsed together with done when the ROI was invalid or the buffer overflowed.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, WAIT_SYNC, WAIT_FRAME, CAPTURE, FINISH.
REQ-015 In IDLE with req nonzero, the block SHALL choose a winner by round-robin: priority goes to the requester after the last served one, and requester 0 has priority after reset.
REQ-016 In the same transition, the block SHALL assert grant the next cycle, latch the winner's ROI, clear wr_addr and the overflow flag, and enter WAIT_SYNC.
REQ-017 If the latched ROI has x0>x1 or y0>y1, the block SHALL go directly to FINISH with err set and SHALL perform no writes.
REQ-018 WAIT_SYNC SHALL wait for iVGA_VS low, then enter WAIT_FRAME; a capture never starts mid-frame.
REQ-019 WAIT_FRAME SHALL wait for iVGA_VS high, then enter CAPTURE.
REQ-020 In CAPTURE, a pixel SHALL qualify when iVGA_BLANK_N=1, x0<=x_count<=x1 and y0<=y_count<=y1 (unsigned compare).
REQ-021 For each qualifying pixel, the block SHALL assert wr_en exactly one cycle later with wr_addr equal to the count of prior qualifying pixels in this capture.
REQ-022 wr_addr SHALL increment after each write.
REQ-023 When wr_addr equals 2^ADDR_W-1 and has just been written, further qualifying pixels SHALL be suppressed: no wr_en, wr_addr holds, and the overflow flag sets.
REQ-024 CAPTURE SHALL exit to FINISH on whichever comes first: iVGA_VS low, or y_count>y1 while iVGA_BLANK_N=0.
REQ-025 In FINISH, for one cycle, the block SHALL pulse done[g] for the granted requester, pulse err if the ROI was invalid or overflow was set, and record g as last served.
REQ-026 The block SHALL deassert grant and return to IDLE the cycle after FINISH; the minimum gap between grants is therefore 1 IDLE cycle.
REQ-027 If req[g] drops in any non-IDLE state, the block SHALL abort: return to IDLE next cycle with no done and no err, record g as last served, and perform no further writes. A wr_en for a pixel sampled on the drop cycle is still issued.
REQ-028 Requests from the non-granted requester SHALL be ignored until IDLE; requesters hold req until done.
REQ-029 grant and done SHALL never both be nonzero for different requesters in the same cycle.

Reset
REQ-030 On reset the block SHALL go to IDLE with grant=0, busy=0, wr_en=0, wr_addr=0, done=0, err=0, overflow clear and last-served=1; reset overrides all inputs, including mid-capture (no done pulse).

Verification
REQ-031 req=01, roi0={2,1,4,2}, 8x4 frame -> grant=01; 6 writes at addr 0..5 in raster order; done=01 after frame end; err=0.
REQ-032 req=11 held through two captures -> first grant=01, then grant=10; with both held again the next grant is 01.
REQ-033 roi0={5,0,3,0} -> no wr_en, and done=01 with err=1 two cycles after grant.
REQ-034 ADDR_W=2 with a 6-pixel ROI -> 4 writes at addr 0..3, then done with err=1.
REQ-035 Request issued mid-frame (iVGA_VS high) -> no wr_en until after the next iVGA_VS low-high transition.
REQ-036 req drop mid-CAPTURE, and separately reset mid-CAPTURE -> busy=0 next cycle, no done, wr_en stops.
